// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory slave for the CPU load/store port. One request is
//   accepted over a valid/ready channel, held for LATENCY wait states,
//   executed against the word array in a single EXEC cycle, and answered over
//   a valid/ready response channel.
//
//   Optional feature: define DMEM_STATS_EN to build the saturating
//   load/store/error counters behind the stat_* ports. Without it the stat_*
//   ports are tied to zero.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt,
  output logic [15:0] stat_err_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EXEC,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH];

  // Address decode of the captured request (offset wraps modulo 2^32).
  logic [31:0]      off;
  logic             addr_err;
  logic [IDX_W-1:0] idx;
  logic             mem_we;
  logic             unused_off_bits;

  assign off             = addr_q - BASE_ADDR;
  assign addr_err        = (addr_q[1:0] != 2'b00) || (off[31:2] >= 30'(DEPTH));
  assign idx             = off[IDX_W+1:2];
  assign mem_we          = (state_q == S_EXEC) && we_q && !addr_err;
  assign unused_off_bits = ^off[1:0];

  assign req_ready = (state_q == S_IDLE) && RST_N;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and response logic for the request/wait/execute/respond FSM.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? S_EXEC : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = addr_err;
        rsp_rdata_d = (we_q || addr_err) ? 32'h0 : mem_q[idx];
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured request and response registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-masked store into the word array during EXEC.
  // NOTE: the storage array has no reset so it can map onto plain RAM.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && be_q[b]) begin
        mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic        rsp_hs;
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  // Saturating per-class counters, stepped on each response handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_cnt_q  <= 16'h0;
      wr_cnt_q  <= 16'h0;
      err_cnt_q <= 16'h0;
    end else if (rsp_hs) begin
      if (rsp_err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign stat_rd_cnt  = rd_cnt_q;
  assign stat_wr_cnt  = wr_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`else
  assign stat_rd_cnt  = 16'h0;
  assign stat_wr_cnt  = 16'h0;
  assign stat_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder: a directed vector table, hand
//   sequences for back-pressure and mid-transaction reset, and a random phase
//   checked against a word-array reference model. Honours DMEM_STATS_EN for
//   the expected stat_* values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned DEPTH     = 256;
  localparam int unsigned LATENCY   = 2;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_err_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          ref_rd, ref_wr, ref_er;

  always #5 CLK = ~CLK;

  dmem_responder #(
    .DEPTH    (DEPTH),
    .LATENCY  (LATENCY),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt),
    .stat_err_cnt(stat_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: word-addressed array with byte-lane stores.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output logic err);
    logic [31:0] off;
    int unsigned word;
    off   = addr - BASE_ADDR;
    word  = off / 4;
    err   = (addr % 4 != 0) || (word >= DEPTH);
    rdata = 32'h0;
    if (err) begin
      ref_er++;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[word][8*b +: 8] = wdata[8*b +: 8];
      ref_wr++;
    end else begin
      rdata = ref_mem[word];
      ref_rd++;
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
    check({tag, "_stat_rd"},  {16'h0, stat_rd_cnt},  32'(ref_rd));
    check({tag, "_stat_wr"},  {16'h0, stat_wr_cnt},  32'(ref_wr));
    check({tag, "_stat_err"}, {16'h0, stat_err_cnt}, 32'(ref_er));
`else
    check({tag, "_stat_rd"},  {16'h0, stat_rd_cnt},  32'h0);
    check({tag, "_stat_wr"},  {16'h0, stat_wr_cnt},  32'h0);
    check({tag, "_stat_err"}, {16'h0, stat_err_cnt}, 32'h0);
`endif
  endtask

  // One full transaction. Edges are counted with the accept edge as edge 1,
  // so the response must first be visible after edge LATENCY+2.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input bit early,
                        output logic [31:0] rdata, output logic err);
    int          n;
    logic [31:0] held;
    @(negedge CLK);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    @(posedge CLK);
    #1;
    // Junk on the request channel must be ignored outside IDLE.
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    if (early) rsp_ready = 1'b1;
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    check("req_ready_after_accept", {31'h0, req_ready}, 32'h0);
    n = 1;
    while (!rsp_valid && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("rsp_latency_edges", 32'(n), 32'(LATENCY + 2));
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        held = rsp_rdata;
        @(posedge CLK);
        #1;
        check("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("hold_rsp_rdata", rsp_rdata, held);
        check("hold_req_ready", {31'h0, req_ready}, 32'h0);
      end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("post_hs_rsp_rdata", rsp_rdata, 32'h0);
    check("post_hs_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'b0101, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'hF,    32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h12,  32'h0,        4'h0,    32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h400, 32'h0,        4'h0,    32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h10,  32'h0,        4'h0,    32'hDE22BE44, 1'b0};
    vecs[8]  = '{1'b1, 32'h14,  32'hFFFFFFFF, 4'h0,    32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h14,  32'h0,        4'h0,    32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h3FC, 32'h0,        4'h0,    32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h3FE, 32'h12345678, 4'hF,    32'h0,        1'b1};

    RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_be = 4'h0; rsp_ready = 1'b0;
    ref_rd = 0; ref_wr = 0; ref_er = 0;

    // Reset state.
    #12;
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    check("rst_busy",      {31'h0, busy}, 32'h0);
    check_stats("rst");
    @(negedge CLK);
    RST_N = 1'b1;

    // Bring every word to a known zero.
    for (int w = 0; w < int'(DEPTH); w++) begin
      do_txn(1'b1, BASE_ADDR + 32'(w * 4), 32'h0, 4'hF, 0, 1'b0, rd, er);
      model_access(1'b1, BASE_ADDR + 32'(w * 4), 32'h0, 4'hF, mrd, mer);
      check("fill_err", {31'h0, er}, 32'h0);
    end
    check_stats("fill");

    // Reset clears counters but leaves storage intact.
    @(negedge CLK);
    RST_N = 1'b0;
    ref_rd = 0; ref_wr = 0; ref_er = 0;
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, 1'b0, rd, er);
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, mrd, mer);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
    end
    check_stats("table");

    // Back-pressure: response held for five cycles.
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, rd, er);
    model_access(1'b0, 32'h10, 32'h0, 4'h0, mrd, mer);
    check("hold_final_rdata", rd, 32'hDE22BE44);

    // Reset during WAIT of a store: dropped, no response, no write.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check("midrst_busy_before", {31'h0, busy}, 32'h1);
    RST_N = 1'b0;
    #1;
    check("midrst_busy",      {31'h0, busy}, 32'h0);
    check("midrst_req_ready", {31'h0, req_ready}, 32'h0);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    check("midrst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    ref_rd = 0; ref_wr = 0; ref_er = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < LATENCY + 3; c++) begin
      @(posedge CLK);
      #1;
      check("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er);
    model_access(1'b0, 32'h20, 32'h0, 4'h0, mrd, mer);
    check("midrst_load_rdata", rd, 32'h0);
    check("midrst_load_err", {31'h0, er}, 32'h0);

    // Random traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      int unsigned sel;
      bit          early;
      int          hold;
      sel   = $urandom_range(0, 15);
      we    = 1'($urandom);
      wdata = $urandom;
      be    = 4'($urandom);
      addr  = BASE_ADDR + 32'($urandom_range(0, DEPTH - 1) * 4);
      if (sel == 0)      addr = addr + 32'($urandom_range(1, 3));
      else if (sel == 1) addr = BASE_ADDR + 32'($urandom_range(DEPTH, DEPTH + 8) * 4);
      else if (sel == 2) addr = $urandom;
      early = ($urandom_range(0, 3) == 0);
      hold  = $urandom_range(0, 3);
      do_txn(we, addr, wdata, be, hold, early, rd, er);
      model_access(we, addr, wdata, be, mrd, mer);
      check("rand_rdata", rd, mrd);
      check("rand_err", {31'h0, er}, {31'h0, mer});
    end
    check_stats("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
